// File: rtl/strhw_block_packer.sv
// Streebog message front-end: packs a byte stream of WORD_BYTES-wide beats into
// 512-bit blocks tagged with byte count, final-block flag and hash-size tag.
module strhw_block_packer #(
   parameter int WORD_BYTES = 8,
   parameter int CNT_W      = $clog2(WORD_BYTES) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [8*WORD_BYTES-1:0] s_data_i,
   input  logic [CNT_W-1:0]        s_bytes_i,
   input  logic                    s_last_i,
   input  logic                    s_hash_size_i,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [511:0]            m_block_o,
   output logic [6:0]              m_block_size_o,
   output logic                    m_last_o,
   output logic                    m_hash_size_o,
   output logic                    err_o
);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_HOLD,
      ST_TAIL
   } state_e;

   localparam logic [CNT_W-1:0] WB_CNT = CNT_W'(WORD_BYTES);

   state_e         state_q, state_d;
   logic [511:0]   asm_q, asm_d;
   logic [6:0]     fill_q, fill_d;
   logic           pend_last_q, pend_last_d;
   logic           owe_tail_q, owe_tail_d;
   logic           first_q, first_d;
   logic           hs_q, hs_d;
   logic           err_q, err_d;
   logic           out_valid_q, out_valid_d;
   logic [511:0]   out_block_q, out_block_d;
   logic [6:0]     out_size_q, out_size_d;
   logic           out_last_q, out_last_d;
   logic           out_hs_q, out_hs_d;

   logic           beat_acc;
   logic           out_free;
   logic           over_len;
   logic           short_beat;
   logic [CNT_W-1:0] nb;
   logic [6:0]     nb7;
   logic           hs_cur;
   logic [511:0]   asm_wr;
   logic [6:0]     fill_wr;
   logic [5:0]     pos;
   logic           blk_full;

   assign s_ready_o = (state_q == ST_FILL) && !rst_i;
   assign beat_acc  = s_valid_i && s_ready_o;
   assign out_free  = !out_valid_q || m_ready_i;

   // Short non-last beats still advance a whole word so blocks stay word-aligned.
   assign over_len   = s_bytes_i > WB_CNT;
   assign short_beat = !s_last_i && (s_bytes_i != WB_CNT);
   assign nb         = (over_len || short_beat) ? WB_CNT : s_bytes_i;
   assign nb7        = 7'(nb);
   assign hs_cur     = first_q ? s_hash_size_i : hs_q;
   assign fill_wr    = fill_q + nb7;
   assign blk_full   = (fill_wr == 7'd64);

   always_comb begin
      asm_wr = asm_q;
      pos    = '0;
      for (int unsigned j = 0; j < WORD_BYTES; j++) begin
         pos = fill_q[5:0] + 6'(j);
         if (7'(j) < nb7) begin
            asm_wr[{pos, 3'b000} +: 8] = s_data_i[8*j +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      fill_d      = fill_q;
      pend_last_d = pend_last_q;
      owe_tail_d  = owe_tail_q;
      first_d     = first_q;
      hs_d        = hs_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_block_d = out_block_q;
      out_size_d  = out_size_q;
      out_last_d  = out_last_q;
      out_hs_d    = out_hs_q;

      if (out_valid_q && m_ready_i) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_FILL: begin
            if (beat_acc) begin
               err_d   = err_q | over_len | short_beat;
               hs_d    = hs_cur;
               first_d = s_last_i;
               if (blk_full || s_last_i) begin
                  if (out_free) begin
                     out_valid_d = 1'b1;
                     out_block_d = asm_wr;
                     out_size_d  = fill_wr;
                     out_last_d  = s_last_i && !blk_full;
                     out_hs_d    = hs_cur;
                     asm_d       = '0;
                     fill_d      = '0;
                     state_d     = (s_last_i && blk_full) ? ST_TAIL : ST_FILL;
                  end else begin
                     asm_d       = asm_wr;
                     fill_d      = fill_wr;
                     pend_last_d = s_last_i && !blk_full;
                     owe_tail_d  = s_last_i && blk_full;
                     state_d     = ST_HOLD;
                  end
               end else begin
                  asm_d  = asm_wr;
                  fill_d = fill_wr;
               end
            end
         end
         ST_HOLD: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_block_d = asm_q;
               out_size_d  = fill_q;
               out_last_d  = pend_last_q;
               out_hs_d    = hs_q;
               asm_d       = '0;
               fill_d      = '0;
               owe_tail_d  = 1'b0;
               state_d     = owe_tail_q ? ST_TAIL : ST_FILL;
            end
         end
         ST_TAIL: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_block_d = '0;
               out_size_d  = '0;
               out_last_d  = 1'b1;
               out_hs_d    = hs_q;
               state_d     = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_FILL;
         asm_q       <= '0;
         fill_q      <= '0;
         pend_last_q <= 1'b0;
         owe_tail_q  <= 1'b0;
         first_q     <= 1'b1;
         hs_q        <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_block_q <= '0;
         out_size_q  <= '0;
         out_last_q  <= 1'b0;
         out_hs_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         fill_q      <= fill_d;
         pend_last_q <= pend_last_d;
         owe_tail_q  <= owe_tail_d;
         first_q     <= first_d;
         hs_q        <= hs_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_block_q <= out_block_d;
         out_size_q  <= out_size_d;
         out_last_q  <= out_last_d;
         out_hs_q    <= out_hs_d;
      end
   end

   assign m_valid_o      = out_valid_q;
   assign m_block_o      = out_block_q;
   assign m_block_size_o = out_size_q;
   assign m_last_o       = out_last_q;
   assign m_hash_size_o  = out_hs_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_strhw_block_packer.sv
// Bench for strhw_block_packer: table-driven messages, hand-written corner
// sequences and randomized traffic checked against a message-level block model.
module tb_strhw_block_packer;

   localparam int WB = 8;
   localparam int CW = 4;

   logic           clk_i;
   logic           rst_i;
   logic           s_valid_i;
   logic           s_ready_o;
   logic [63:0]    s_data_i;
   logic [CW-1:0]  s_bytes_i;
   logic           s_last_i;
   logic           s_hash_size_i;
   logic           m_valid_o;
   logic           m_ready_i;
   logic [511:0]   m_block_o;
   logic [6:0]     m_block_size_o;
   logic           m_last_o;
   logic           m_hash_size_o;
   logic           err_o;

   strhw_block_packer #(.WORD_BYTES(WB), .CNT_W(CW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .s_valid_i      (s_valid_i),
      .s_ready_o      (s_ready_o),
      .s_data_i       (s_data_i),
      .s_bytes_i      (s_bytes_i),
      .s_last_i       (s_last_i),
      .s_hash_size_i  (s_hash_size_i),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .m_block_o      (m_block_o),
      .m_block_size_o (m_block_size_o),
      .m_last_o       (m_last_o),
      .m_hash_size_o  (m_hash_size_o),
      .err_o          (err_o)
   );

   typedef struct {
      logic [511:0] data;
      int           size;
      bit           last;
      bit           hs;
   } blk_t;

   typedef struct {
      int len;
      bit hs;
      bit term;
      int exp_blocks;
      int exp_last;
   } vec_t;

   blk_t        exp_q[$];
   blk_t        got_q[$];
   logic [7:0]  msg_q[$];
   int          checks = 0;
   int          errors = 0;
   int          rdy_mode = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1);
   end

   // 0: always ready, 1: random, 2: stalled
   initial begin
      m_ready_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
         endcase
      end
   end

   initial begin
      forever begin
         blk_t b;
         @(negedge clk_i);
         if (!rst_i && m_valid_o && m_ready_i) begin
            b.data = m_block_o;
            b.size = int'(m_block_size_o);
            b.last = m_last_o;
            b.hs   = m_hash_size_o;
            got_q.push_back(b);
         end
      end
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Every 64 complete bytes form a full block; the remainder (possibly 0) is the final block.
   task automatic model_msg(input int len, input bit hs);
      int nfull;
      blk_t b;
      nfull = len / 64;
      for (int blk = 0; blk <= nfull; blk++) begin
         b.data = '0;
         b.size = (blk < nfull) ? 64 : (len % 64);
         b.last = (blk == nfull);
         b.hs   = hs;
         for (int k = 0; k < b.size; k++) b.data[8*k +: 8] = msg_q[blk*64 + k];
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [63:0] beat_data(input int pos, input int len);
      logic [63:0] d;
      for (int j = 0; j < WB; j++) begin
         d[8*j +: 8] = (pos + j < len) ? msg_q[pos + j] : 8'($urandom);
      end
      return d;
   endfunction

   task automatic send_beat(input logic [63:0] data, input int bytes, input bit last,
                            input bit hs, input bit gap);
      bit acc;
      int t;
      s_valid_i = 1'b0;
      if (gap) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i);
            #1;
         end
      end
      s_valid_i     = 1'b1;
      s_data_i      = data;
      s_bytes_i     = CW'(bytes);
      s_last_i      = last;
      s_hash_size_i = hs;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 300) begin
         @(negedge clk_i);
         acc = s_ready_o;
         @(posedge clk_i);
         #1;
         t++;
      end
      s_valid_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout actual=not_accepted required=accepted");
      end
   endtask

   task automatic send_msg(input int len, input bit hs, input bit term, input bit rnd, input bit gap);
      int  pos;
      int  rem;
      bit  first;
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(rnd ? 8'($urandom) : i[7:0]);
      model_msg(len, hs);
      pos   = 0;
      first = 1'b1;
      forever begin
         rem = len - pos;
         if (rem > WB || (rem == WB && term)) begin
            send_beat(beat_data(pos, len), WB, 1'b0, first ? hs : ~hs, gap);
            pos += WB;
         end else begin
            send_beat(beat_data(pos, len), rem, 1'b1, first ? hs : ~hs, gap);
            break;
         end
         first = 1'b0;
      end
   endtask

   task automatic wait_blocks();
      int t;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 3000) begin
         @(posedge clk_i);
         t++;
      end
      repeat (4) @(posedge clk_i);
      #1;
   endtask

   task automatic compare_blocks(input string name);
      chk($sformatf("%s_count", name), 512'(got_q.size()), 512'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_b%0d_data", name, i), got_q[i].data, exp_q[i].data);
         chk($sformatf("%s_b%0d_size", name, i), 512'(got_q[i].size), 512'(exp_q[i].size));
         chk($sformatf("%s_b%0d_last", name, i), 512'(got_q[i].last), 512'(exp_q[i].last));
         chk($sformatf("%s_b%0d_hs", name, i), 512'(got_q[i].hs), 512'(exp_q[i].hs));
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      vec_t        tbl[9];
      logic [511:0] held;

      tbl[0] = '{0,   1'b1, 1'b0, 1, 0};
      tbl[1] = '{64,  1'b0, 1'b0, 2, 0};
      tbl[2] = '{65,  1'b1, 1'b0, 2, 1};
      tbl[3] = '{8,   1'b1, 1'b0, 1, 8};
      tbl[4] = '{64,  1'b1, 1'b1, 2, 0};
      tbl[5] = '{128, 1'b0, 1'b0, 3, 0};
      tbl[6] = '{127, 1'b0, 1'b0, 2, 63};
      tbl[7] = '{3,   1'b1, 1'b0, 1, 3};
      tbl[8] = '{16,  1'b0, 1'b1, 1, 16};

      rst_i = 1'b1;
      s_valid_i = 1'b0;
      s_data_i = '0;
      s_bytes_i = '0;
      s_last_i = 1'b0;
      s_hash_size_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready",  512'(s_ready_o), 512'(0));
      chk("rst_valid",  512'(m_valid_o), 512'(0));
      chk("rst_block",  m_block_o, '0);
      chk("rst_size",   512'(m_block_size_o), 512'(0));
      chk("rst_last",   512'(m_last_o), 512'(0));
      chk("rst_hs",     512'(m_hash_size_o), 512'(0));
      chk("rst_err",    512'(err_o), 512'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_release_ready", 512'(s_ready_o), 512'(1));
      @(posedge clk_i);
      #1;

      rdy_mode = 0;
      for (int v = 0; v < 9; v++) begin
         send_msg(tbl[v].len, tbl[v].hs, tbl[v].term, 1'b0, 1'b0);
         wait_blocks();
         chk($sformatf("tbl%0d_nblocks", v), 512'(got_q.size()), 512'(tbl[v].exp_blocks));
         if (got_q.size() > 0)
            chk($sformatf("tbl%0d_last_size", v), 512'(got_q[got_q.size()-1].size),
                512'(tbl[v].exp_last));
         compare_blocks($sformatf("tbl%0d", v));
      end

      // Terminator latency: size-64 block one cycle after the last beat, size-0 block the next.
      send_msg(64, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("tail_b1_valid", 512'(m_valid_o), 512'(1));
      chk("tail_b1_size",  512'(m_block_size_o), 512'(64));
      chk("tail_b1_last",  512'(m_last_o), 512'(0));
      @(negedge clk_i);
      chk("tail_b2_valid", 512'(m_valid_o), 512'(1));
      chk("tail_b2_size",  512'(m_block_size_o), 512'(0));
      chk("tail_b2_last",  512'(m_last_o), 512'(1));
      wait_blocks();
      compare_blocks("tail");

      // Back-pressure on a 192-byte message.
      rdy_mode = 2;
      repeat (2) @(posedge clk_i);
      #1;
      msg_q.delete();
      for (int i = 0; i < 192; i++) msg_q.push_back(8'($urandom));
      model_msg(192, 1'b1);
      for (int b = 0; b < 16; b++) send_beat(beat_data(b*8, 192), 8, 1'b0, 1'b1, 1'b0);
      @(negedge clk_i);
      chk("bp_ready_low", 512'(s_ready_o), 512'(0));
      chk("bp_valid",     512'(m_valid_o), 512'(1));
      held = m_block_o;
      repeat (12) @(negedge clk_i);
      chk("bp_ready_still_low", 512'(s_ready_o), 512'(0));
      chk("bp_stable_block",    m_block_o, held);
      chk("bp_stable_size",     512'(m_block_size_o), 512'(64));
      @(posedge clk_i);
      #1;
      rdy_mode = 0;
      for (int b = 16; b < 24; b++) send_beat(beat_data(b*8, 192), 8, (b == 23), 1'b0, 1'b0);
      wait_blocks();
      compare_blocks("bp");

      // Protocol error: short non-last beat, then back-to-back messages with different tags.
      chk("err_before", 512'(err_o), 512'(0));
      msg_q.delete();
      for (int i = 0; i < 10; i++) msg_q.push_back(8'($urandom));
      model_msg(10, 1'b0);
      send_beat(beat_data(0, 10), 5, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("err_rise", 512'(err_o), 512'(1));
      @(posedge clk_i);
      #1;
      send_beat(beat_data(8, 10), 2, 1'b1, 1'b1, 1'b0);
      msg_q.delete();
      for (int i = 0; i < 3; i++) msg_q.push_back(8'($urandom));
      model_msg(3, 1'b1);
      send_beat(beat_data(0, 3), 3, 1'b1, 1'b1, 1'b0);
      wait_blocks();
      compare_blocks("err");
      chk("err_sticky", 512'(err_o), 512'(1));

      // Reset in the middle of a message.
      msg_q.delete();
      for (int i = 0; i < 24; i++) msg_q.push_back(8'($urandom));
      for (int b = 0; b < 3; b++) send_beat(beat_data(b*8, 24), 8, 1'b0, 1'b1, 1'b0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mrst_ready_in_reset", 512'(s_ready_o), 512'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("mrst_valid", 512'(m_valid_o), 512'(0));
      chk("mrst_block", m_block_o, '0);
      chk("mrst_size",  512'(m_block_size_o), 512'(0));
      chk("mrst_last",  512'(m_last_o), 512'(0));
      chk("mrst_hs",    512'(m_hash_size_o), 512'(0));
      chk("mrst_err",   512'(err_o), 512'(0));
      chk("mrst_ready", 512'(s_ready_o), 512'(1));
      @(posedge clk_i);
      #1;
      send_msg(8, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_blocks();
      compare_blocks("mrst");

      // Oversized byte count on a last beat is clamped to a full word.
      msg_q.delete();
      for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom));
      model_msg(8, 1'b0);
      send_beat(beat_data(0, 8), 12, 1'b1, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("clamp_err", 512'(err_o), 512'(1));
      wait_blocks();
      compare_blocks("clamp");

      rdy_mode = 1;
      for (int m = 0; m < 40; m++) begin
         send_msg($urandom_range(0, 200), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b1, 1'($urandom_range(0, 1)));
      end
      wait_blocks();
      compare_blocks("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
